// File: rtl/event_flasher_pkg.sv
// event_flasher_pkg
// Shared definitions for the LED-indicator blocks (event_flasher, debounce, PWM):
//   - flash_state_e : 2-bit FSM encoding IDLE / ON / OFF
//   - ms_to_cycles  : milliseconds -> clock cycles at a given clock frequency
//   - timer_width   : down-timer width able to hold max(a, b) - 1, never 0 bits
package event_flasher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } flash_state_e;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    return (clk_freq / 1000) * ms;
  endfunction

  // A timer loaded with (n - 1) needs clog2(n) bits; clamp to 1 so a
  // one-cycle phase still gets a legal vector.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/event_flasher_down_timer.sv
// down_timer
// Loadable down-counter with a zero flag. A load takes priority; otherwise the
// count decrements and rests at zero.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset (count -> 0)
//   load                : load load_val on this edge
//   load_val [W-1:0]    : value to load
//   count    [W-1:0]    : current count (registered)
//   zero                : count == 0
module down_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/event_flasher.sv
// event_flasher
// Turns single-cycle events into human-visible LED flashes: each accepted event
// gives ON_CYCLES of LED on followed by OFF_CYCLES of LED off. Events arriving
// while a flash is running are counted (saturating) and replayed back-to-back.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   event_in              : one event per cycle sampled high
//   led_out               : registered LED drive, 1 = on (high exactly in ON)
//   busy                  : registered, 1 whenever the FSM is not IDLE
//   pending [PEND_W-1:0]  : registered count of queued, not yet flashed events
//   overflow              : registered one-cycle pulse when an event is dropped
//   state_dbg [1:0]       : current FSM state (flash_state_e encoding)
// Handshake: event_in is a fire-and-forget pulse with no ready; every sampled
// high cycle is either flashed, queued, or dropped with an overflow pulse.
import event_flasher_pkg::*;

module event_flasher #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned ON_MS    = 50,
  parameter int unsigned OFF_MS   = 50,
  parameter int unsigned PEND_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              event_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic [1:0]        state_dbg
);

  localparam int unsigned ON_CYCLES  = ms_to_cycles(CLK_FREQ, ON_MS);
  localparam int unsigned OFF_CYCLES = ms_to_cycles(CLK_FREQ, OFF_MS);
  localparam int unsigned TIMER_W    = timer_width(ON_CYCLES, OFF_CYCLES);

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX = {PEND_W{1'b1}};

  flash_state_e       state, next_state;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_val;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_zero;
  logic               off_to_on;
  logic               inc, dec;
  logic [PEND_W-1:0]  pending_next;
  logic               overflow_next;

  down_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .count    (timer_count),
    .zero     (timer_zero)
  );

  always_comb begin
    next_state     = state;
    timer_load     = 1'b0;
    timer_load_val = '0;
    off_to_on      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (event_in) begin
          next_state     = ST_ON;
          timer_load     = 1'b1;
          timer_load_val = ON_LOAD;
        end
      end
      ST_ON: begin
        if (timer_zero) begin
          next_state     = ST_OFF;
          timer_load     = 1'b1;
          timer_load_val = OFF_LOAD;
        end
      end
      ST_OFF: begin
        if (timer_zero) begin
          if ((pending != '0) || event_in) begin
            next_state     = ST_ON;
            timer_load     = 1'b1;
            timer_load_val = ON_LOAD;
            off_to_on      = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // A restart always prefers the queue: with pending > 0 the new event is
  // queued while a queued one is consumed; with pending == 0 the new event
  // is flashed directly and never enters the queue.
  always_comb begin
    inc           = event_in && ((state == ST_ON) || (state == ST_OFF)) &&
                    !(off_to_on && (pending == '0));
    dec           = off_to_on && (pending != '0);
    pending_next  = pending;
    overflow_next = 1'b0;
    if (inc && !dec) begin
      if (pending == PEND_MAX) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending + PEND_W'(1);
      end
    end else if (dec && !inc) begin
      pending_next = pending - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      led_out  <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= next_state;
      led_out  <= (next_state == ST_ON);
      busy     <= (next_state != ST_IDLE);
      pending  <= pending_next;
      overflow <= overflow_next;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_event_flasher.sv
// tb_event_flasher
// Bench for event_flasher with CLK_FREQ = 1000 (1 ms = 1 cycle), ON = 3,
// OFF = 2, PEND_W = 2. Each scenario pushes the per-edge expected outputs
// {led_out, busy, pending, overflow} derived from the flash timeline, then
// drives event_in on falling edges and compares 1 time unit after each rising
// edge. Edge index i of a scenario is the i-th rising edge of that run.
module tb_event_flasher;

  localparam int unsigned PEND_W = 2;
  localparam int unsigned EXP_W  = 4 + PEND_W;

  logic              clk;
  logic              reset_n;
  logic              event_in;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;
  logic [1:0]        state_dbg;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks;
  int n_fails;

  event_flasher #(
    .CLK_FREQ (1000),
    .ON_MS    (3),
    .OFF_MS   (2),
    .PEND_W   (PEND_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .event_in  (event_in),
    .led_out   (led_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  // Record layout: {led_out, busy, pending, overflow, idle_state}.
  task automatic push_exp(input logic led, input logic bsy,
                          input logic [PEND_W-1:0] p, input logic ovf,
                          input int count);
    for (int i = 0; i < count; i++)
      exp_q.push_back({led, bsy, p, ovf, (!bsy)});
  endtask

  // Drives ev[i] before edge i and checks the scoreboard after each edge.
  task automatic run_scenario(input string name, input logic [63:0] ev,
                              input int n);
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] act_v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      event_in = ev[i];
      @(posedge clk);
      #1;
      act_v = {led_out, busy, pending, overflow, (state_dbg == 2'd0)};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL %s edge %0d: scoreboard empty, got %b", name, i, act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          n_fails++;
          $display("FAIL %s edge %0d: got {led,busy,pend,ovf,idle}=%b expected %b",
                   name, i, act_v, exp_v);
        end
      end
    end
    @(negedge clk);
    event_in = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL %s: %0d expected entries left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n  = 1'b0;
    event_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      event_in = ~event_in;
      @(posedge clk);
      #1;
      n_checks++;
      if ({led_out, busy, pending, overflow, state_dbg} !== '0) begin
        n_fails++;
        $display("FAIL reset_hold cycle %0d: got led=%b busy=%b pend=%0d ovf=%b st=%0d expected all 0",
                 i, led_out, busy, pending, overflow, state_dbg);
      end
    end
    @(negedge clk);
    event_in = 1'b0;
    reset_n  = 1'b1;
    push_exp(0, 0, 0, 0, 8);
    run_scenario("reset_release", 64'd0, 8);
  endtask

  task automatic test_single_event();
    logic [63:0] ev;
    ev = '0;
    ev[10] = 1'b1;
    push_exp(0, 0, 0, 0, 10);
    push_exp(1, 1, 0, 0, 3);
    push_exp(0, 1, 0, 0, 2);
    push_exp(0, 0, 0, 0, 5);
    run_scenario("single_event", ev, 20);
  endtask

  task automatic test_queueing();
    logic [63:0] ev;
    ev = '0;
    ev[10] = 1'b1; ev[11] = 1'b1; ev[12] = 1'b1;
    push_exp(0, 0, 0, 0, 10);
    push_exp(1, 1, 0, 0, 1);
    push_exp(1, 1, 1, 0, 1);
    push_exp(1, 1, 2, 0, 1);
    push_exp(0, 1, 2, 0, 2);
    push_exp(1, 1, 1, 0, 3);   // second flash from queue at edge 15
    push_exp(0, 1, 1, 0, 2);
    push_exp(1, 1, 0, 0, 3);   // third flash at edge 20
    push_exp(0, 1, 0, 0, 2);
    push_exp(0, 0, 0, 0, 5);   // idle from edge 25
    run_scenario("queueing", ev, 30);
  endtask

  task automatic test_overflow();
    logic [63:0] ev;
    ev = '0;
    for (int i = 10; i <= 14; i++) ev[i] = 1'b1;
    push_exp(0, 0, 0, 0, 10);
    push_exp(1, 1, 0, 0, 1);
    push_exp(1, 1, 1, 0, 1);
    push_exp(1, 1, 2, 0, 1);
    push_exp(0, 1, 3, 0, 1);
    push_exp(0, 1, 3, 1, 1);   // edge 14: event dropped
    push_exp(1, 1, 2, 0, 3);
    push_exp(0, 1, 2, 0, 2);
    push_exp(1, 1, 1, 0, 3);
    push_exp(0, 1, 1, 0, 2);
    push_exp(1, 1, 0, 0, 3);   // fourth and last flash
    push_exp(0, 1, 0, 0, 2);
    push_exp(0, 0, 0, 0, 5);
    run_scenario("overflow", ev, 35);
  endtask

  task automatic test_back_to_back();
    logic [63:0] ev;
    // Event on the edge that ends OFF (edge 15) with nothing queued.
    ev = '0;
    ev[10] = 1'b1; ev[15] = 1'b1;
    push_exp(0, 0, 0, 0, 10);
    push_exp(1, 1, 0, 0, 3);
    push_exp(0, 1, 0, 0, 2);
    push_exp(1, 1, 0, 0, 3);
    push_exp(0, 1, 0, 0, 2);
    push_exp(0, 0, 0, 0, 5);
    run_scenario("simul_pend0", ev, 25);
    // Same, but one event already queued.
    ev = '0;
    ev[10] = 1'b1; ev[11] = 1'b1; ev[15] = 1'b1;
    push_exp(0, 0, 0, 0, 10);
    push_exp(1, 1, 0, 0, 1);
    push_exp(1, 1, 1, 0, 2);
    push_exp(0, 1, 1, 0, 2);
    push_exp(1, 1, 1, 0, 3);
    push_exp(0, 1, 1, 0, 2);
    push_exp(1, 1, 0, 0, 3);
    push_exp(0, 1, 0, 0, 2);
    push_exp(0, 0, 0, 0, 5);
    run_scenario("simul_pend1", ev, 30);
  endtask

  task automatic test_reset_mid_flash();
    logic [63:0] ev;
    ev = '0;
    ev[10] = 1'b1; ev[11] = 1'b1; ev[12] = 1'b1;
    push_exp(0, 0, 0, 0, 10);
    push_exp(1, 1, 0, 0, 1);
    push_exp(1, 1, 1, 0, 1);
    push_exp(1, 1, 2, 0, 1);
    run_scenario("pre_reset", ev, 13);
    // Mid-cycle, away from any edge: reset must act without a clock.
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({led_out, busy, pending, overflow, state_dbg} !== '0) begin
      n_fails++;
      $display("FAIL reset_mid_flash: got led=%b busy=%b pend=%0d ovf=%b st=%0d expected all 0",
               led_out, busy, pending, overflow, state_dbg);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ev = '0;
    ev[4] = 1'b1;
    push_exp(0, 0, 0, 0, 4);
    push_exp(1, 1, 0, 0, 3);
    push_exp(0, 1, 0, 0, 2);
    push_exp(0, 0, 0, 0, 4);
    run_scenario("post_reset_flash", ev, 13);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_n  = 1'b0;
    event_in = 1'b0;
    test_reset();
    test_single_event();
    test_queueing();
    test_overflow();
    test_back_to_back();
    test_reset_mid_flash();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
